io_key_debounce: RTL and testbench
==================================

IO_KEY_DEBOUNCE -- requirements
Module: io_key_debounce

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 4, giving the number of pushbutton inputs; legal range 1..8.
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 500000, giving the consecutive-cycle count required to accept a level change (10 ms at 50 MHz); legal range 2..2^20-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port i_keys_raw, input, NUM_KEYS bits: asynchronous board pushbuttons, active-low (0 = pressed).
REQ-006 The block SHALL have port i_evt_clr, input, NUM_KEYS bits: per-key clear strobe for the sticky event flags, driven by software store logic.
REQ-007 The block SHALL have port o_keys, output, 32 bits: debounced pressed state, active-high, bits[NUM_KEYS-1:0] valid, upper bits 0; feeds the LSU io_keys_i input directly.
REQ-008 The block SHALL have port o_press_pulse, output, NUM_KEYS bits: one-cycle strobe per accepted press.
REQ-009 The block SHALL have port o_release_pulse, output, NUM_KEYS bits: one-cycle strobe per accepted release.
REQ-010 The block SHALL have port o_key_evt, output, NUM_KEYS bits: sticky "pressed since last clear" flags.

Function
REQ-011 Each raw bit SHALL pass through a 2-flop synchronizer; no logic SHALL use i_keys_raw before the second flop.
REQ-012 Synchronized value SHALL be inverted to active-high pressed before comparison with the stable state.
REQ-013 Each key SHALL run an independent FSM with states UP, CHK_DOWN, DOWN and CHK_UP.
- UP -> CHK_DOWN when pressed is sampled.
- CHK_DOWN -> DOWN when the count completes; -> UP on any released sample.
- DOWN -> CHK_UP when released is sampled.
- CHK_UP -> UP when the count completes; -> DOWN on any pressed sample.
REQ-014 Each key SHALL have a counter of ceil(log2(STABLE_CYCLES)) bits.
- Cleared in UP/DOWN and on any abort back to UP/DOWN.
- Increments each cycle in CHK_DOWN/CHK_UP while the sample still differs from the stable state.
- Completes on the edge where the count of consecutive differing samples equals STABLE_CYCLES; it shall not wrap.
REQ-015 A raw change held steady SHALL appear on o_keys at the (STABLE_CYCLES+2)th rising edge after the first edge that samples it (2 synchronizer + STABLE_CYCLES count).
REQ-016 A glitch lasting fewer than STABLE_CYCLES synchronized cycles SHALL leave o_keys, the pulses and o_key_evt unchanged and return the counter to 0.
REQ-017 o_press_pulse[k] SHALL be 1 for exactly the one cycle following the edge on which o_keys[k] rises; o_release_pulse[k] likewise for the fall.
REQ-018 o_key_evt[k] SHALL set on o_press_pulse[k] and clear on i_evt_clr[k]; simultaneous set and clear SHALL leave it set.
REQ-019 Keys SHALL be fully independent; simultaneous transitions on multiple keys SHALL each be processed with identical latency.
REQ-020 All outputs SHALL be registered; no combinational path SHALL exist from any input to any output.

Reset
REQ-021 While rst=1 at a clock edge, the following SHALL hold:
- Synchronizer flops load 1 (released).
- FSMs go to UP and counters to 0.
- o_keys, o_press_pulse, o_release_pulse and o_key_evt go to 0.
REQ-022 Reset asserted mid-count SHALL abort the count; a key still held at reset release SHALL be reported pressed STABLE_CYCLES+2 edges after the first post-reset edge.
REQ-023 No output SHALL pulse as a result of reset entry or exit.

Verification (NUM_KEYS=4, STABLE_CYCLES=8)
REQ-024 Key press: hold i_keys_raw=4'b1110 steady.
- Required: o_keys=32'h1 on edge 10.
- Required: o_press_pulse=4'b0001 for one cycle.
- Required: o_key_evt[0]=1.
REQ-025 Glitch: i_keys_raw[1]=0 for 5 cycles then 1.
- Required: o_keys, pulses and o_key_evt unchanged.
- Required: a following 10-cycle press registers on edge 10 of that press.
REQ-026 Bounce: toggle key2 every 3 cycles for 30 cycles, then hold 0.
- Required: exactly one press pulse, 10 edges after the final settle.
REQ-027 Release and clear:
- Release key0 → o_release_pulse=4'b0001 once, o_keys=0.
- i_evt_clr=4'b0001 → o_key_evt[0]=0 next cycle.
- Clear on the same cycle as a press pulse → flag stays 1.
REQ-028 Reset mid-count: assert rst at count 5 with key3 held.
- Required: all outputs 0 and no pulse.
- Required: after release o_keys=32'h8 exactly 10 edges later.
REQ-029 Multi-key: press keys 0 and 3 on the same cycle.
- Required: o_keys=32'h9 and o_press_pulse=4'b1001 on the same edge.
- Required: o_keys[31:4] stays 0 throughout.

Source files
------------

// File: rtl/io_key_debounce.sv
// Pushbutton conditioner: 2-flop sync, per-key debounce FSM,
// edge strobes and sticky press flags for the LSU key register.
module io_key_debounce #(
  parameter int NUM_KEYS      = 4,
  parameter int STABLE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] i_keys_raw,
  input  logic [NUM_KEYS-1:0] i_evt_clr,
  output logic [31:0]         o_keys,
  output logic [NUM_KEYS-1:0] o_press_pulse,
  output logic [NUM_KEYS-1:0] o_release_pulse,
  output logic [NUM_KEYS-1:0] o_key_evt
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    UP       = 2'd0,
    CHK_DOWN = 2'd1,
    DOWN     = 2'd2,
    CHK_UP   = 2'd3
  } state_e;

  logic [NUM_KEYS-1:0] sync_q1;
  logic [NUM_KEYS-1:0] sync_q2;
  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] fall;
  logic [NUM_KEYS-1:0] keys_q;

  // Released (1) is the safe reset value for active-low buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= i_keys_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign pressed = ~sync_q2;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          key_rise;
    logic          key_fall;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= UP;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Entering a CHK state counts that sample as the first one
    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
        UP: begin
          if (pressed[k]) begin
            state_d = CHK_DOWN;
            cnt_d   = CW'(1);
          end
        end
        CHK_DOWN: begin
          if (!pressed[k]) begin
            state_d = UP;
          end else if (cnt_q == CNT_LAST) begin
            state_d = DOWN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DOWN: begin
          if (!pressed[k]) begin
            state_d = CHK_UP;
            cnt_d   = CW'(1);
          end
        end
        CHK_UP: begin
          if (pressed[k]) begin
            state_d = DOWN;
          end else if (cnt_q == CNT_LAST) begin
            state_d = UP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = UP;
        end
      endcase
    end

    always_comb begin
      key_rise = 1'b0;
      key_fall = 1'b0;
      if (state_q == CHK_DOWN && state_d == DOWN) begin
        key_rise = 1'b1;
      end
      if (state_q == CHK_UP && state_d == UP) begin
        key_fall = 1'b1;
      end
    end

    assign rise[k] = key_rise;
    assign fall[k] = key_fall;
  end

  // Set wins over clear both on the accept edge and in the strobe cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      keys_q          <= '0;
      o_press_pulse   <= '0;
      o_release_pulse <= '0;
      o_key_evt       <= '0;
    end else begin
      keys_q          <= (keys_q | rise) & ~fall;
      o_press_pulse   <= rise;
      o_release_pulse <= fall;
      o_key_evt       <= (o_key_evt & ~i_evt_clr) | rise | o_press_pulse;
    end
  end

  assign o_keys = {{(32 - NUM_KEYS){1'b0}}, keys_q};

endmodule

// File: tb/tb_io_key_debounce.sv
// Directed bench for io_key_debounce with NUM_KEYS=4, STABLE_CYCLES=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_io_key_debounce;

  logic        clk;
  logic        rst;
  logic [3:0]  i_keys_raw;
  logic [3:0]  i_evt_clr;
  logic [31:0] o_keys;
  logic [3:0]  o_press_pulse;
  logic [3:0]  o_release_pulse;
  logic [3:0]  o_key_evt;

  int checks;
  int failures;

  io_key_debounce #(
    .NUM_KEYS(4),
    .STABLE_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_keys_raw(i_keys_raw),
    .i_evt_clr(i_evt_clr),
    .o_keys(o_keys),
    .o_press_pulse(o_press_pulse),
    .o_release_pulse(o_release_pulse),
    .o_key_evt(o_key_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] k,
                         input logic [3:0] p, input logic [3:0] r,
                         input logic [3:0] e);
    chk({tag, "_keys"}, o_keys, k);
    chk({tag, "_press"}, {28'd0, o_press_pulse}, {28'd0, p});
    chk({tag, "_rel"}, {28'd0, o_release_pulse}, {28'd0, r});
    chk({tag, "_evt"}, {28'd0, o_key_evt}, {28'd0, e});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    i_keys_raw = 4'b1111;
    i_evt_clr  = 4'b0000;
    @(posedge clk);
    #1;
    cyc(3);
    chk_all("reset", 32'h0, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    cyc(2);
    chk_all("idle", 32'h0, 4'h0, 4'h0, 4'h0);

    // key0 press
    i_keys_raw = 4'b1110;
    cyc(9);
    chk("press0_e9", o_keys, 32'h0);
    cyc(1);
    chk_all("press0_e10", 32'h1, 4'b0001, 4'h0, 4'b0001);
    cyc(1);
    chk_all("press0_e11", 32'h1, 4'h0, 4'h0, 4'b0001);

    // key1 glitch of 5 cycles
    i_keys_raw = 4'b1100;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk_all("glitch1", 32'h1, 4'h0, 4'h0, 4'b0001);
    end
    i_keys_raw = 4'b1110;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      chk_all("glitch1_after", 32'h1, 4'h0, 4'h0, 4'b0001);
    end

    // key1 10-cycle press after glitch
    i_keys_raw = 4'b1100;
    cyc(9);
    chk("press1_e9", o_keys, 32'h1);
    cyc(1);
    chk_all("press1_e10", 32'h3, 4'b0010, 4'h0, 4'b0011);
    i_keys_raw = 4'b1110;
    cyc(9);
    chk("rel1_e9", o_keys, 32'h3);
    cyc(1);
    chk_all("rel1_e10", 32'h1, 4'h0, 4'b0010, 4'b0011);
    i_evt_clr = 4'b0010;
    cyc(1);
    i_evt_clr = 4'b0000;
    chk_all("clr1", 32'h1, 4'h0, 4'h0, 4'b0001);

    // key2 bounce: 10 segments of 3 cycles, then settle pressed
    for (int s = 0; s < 10; s++) begin
      i_keys_raw = (s % 2 == 0) ? 4'b1010 : 4'b1110;
      for (int i = 0; i < 3; i++) begin
        cyc(1);
        chk_all("bounce2", 32'h1, 4'h0, 4'h0, 4'b0001);
      end
    end
    i_keys_raw = 4'b1010;
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      chk_all("settle2", 32'h1, 4'h0, 4'h0, 4'b0001);
    end
    cyc(1);
    chk_all("press2_e10", 32'h5, 4'b0100, 4'h0, 4'b0101);
    cyc(1);
    chk_all("press2_e11", 32'h5, 4'h0, 4'h0, 4'b0101);

    // key0 release, then clear its flag
    i_keys_raw = 4'b1011;
    cyc(9);
    chk("rel0_e9", o_keys, 32'h5);
    cyc(1);
    chk_all("rel0_e10", 32'h4, 4'h0, 4'b0001, 4'b0101);
    cyc(1);
    chk_all("rel0_e11", 32'h4, 4'h0, 4'h0, 4'b0101);
    i_evt_clr = 4'b0001;
    cyc(1);
    i_evt_clr = 4'b0000;
    chk_all("clr0", 32'h4, 4'h0, 4'h0, 4'b0100);

    // key0 re-press with clear during the strobe cycle
    i_keys_raw = 4'b1010;
    cyc(10);
    chk_all("repress0", 32'h5, 4'b0001, 4'h0, 4'b0101);
    i_evt_clr = 4'b0001;
    cyc(1);
    i_evt_clr = 4'b0000;
    chk_all("clr_vs_set", 32'h5, 4'h0, 4'h0, 4'b0101);
    cyc(1);
    chk("clr_vs_set_hold", {28'd0, o_key_evt}, 32'h5);

    // release all, clear all
    i_keys_raw = 4'b1111;
    cyc(10);
    chk_all("rel_all", 32'h0, 4'h0, 4'b0101, 4'b0101);
    i_evt_clr = 4'b1111;
    cyc(1);
    i_evt_clr = 4'b0000;
    chk_all("clr_all", 32'h0, 4'h0, 4'h0, 4'h0);

    // key3 held, reset at count 5
    i_keys_raw = 4'b0111;
    cyc(7);
    chk_all("pre_rst", 32'h0, 4'h0, 4'h0, 4'h0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk_all("in_rst", 32'h0, 4'h0, 4'h0, 4'h0);
    end
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      chk_all("post_rst", 32'h0, 4'h0, 4'h0, 4'h0);
    end
    cyc(1);
    chk_all("press3_e10", 32'h8, 4'b1000, 4'h0, 4'b1000);
    i_keys_raw = 4'b1111;
    cyc(10);
    chk_all("rel3", 32'h0, 4'h0, 4'b1000, 4'b1000);
    i_evt_clr = 4'b1111;
    cyc(1);
    i_evt_clr = 4'b0000;
    chk("clr3", {28'd0, o_key_evt}, 32'h0);

    // keys 0 and 3 together
    i_keys_raw = 4'b0110;
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      chk_all("multi_wait", 32'h0, 4'h0, 4'h0, 4'h0);
    end
    cyc(1);
    chk_all("multi_e10", 32'h9, 4'b1001, 4'h0, 4'b1001);
    cyc(1);
    chk_all("multi_e11", 32'h9, 4'h0, 4'h0, 4'b1001);
    chk("multi_upper", {4'd0, o_keys[31:4]}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
